// File: rtl/popcount_unary_tx.sv
// popcount_unary_tx: turns a binary count into an N-bit unary frame.
// The frame is loaded in parallel as a thermometer word (therm_o) and is
// also sent one bit per cycle on a valid/ready stream.
// Optional build macro: POPCOUNT_UNARY_SPREAD_EN. When it is defined, the ones
// in the serial frame are spread evenly across the frame instead of coming
// first. therm_o is thermometer-coded in both builds.
//
// Handshakes: a transfer takes place on a rising clk edge where valid and
// ready are both high. A source that raises valid keeps it high, with its
// data stable, until that transfer. In this block cnt_ready_o is high only in
// IDLE. bit_valid_o is high only in SEND. While the bit stream stalls,
// bit_o and bit_last_o do not change.
module popcount_unary_tx #(
    parameter int N  = 35,
    parameter int CW = 6,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cnt_i,
    input  logic          cnt_valid_i,
    output logic          cnt_ready_o,
    output logic          bit_o,
    output logic          bit_valid_o,
    input  logic          bit_ready_i,
    output logic          bit_last_o,
    output logic [N-1:0]  therm_o,
    output logic          therm_valid_o,
    output logic          clamp_o,
    output logic          busy_o
);

    localparam int IW = $clog2(N);

    // Stop elaboration if the parameters cannot hold the counts or sums.
    if ((2 ** CW) <= N || (2 ** AW) < 2 * N) begin : g_param_check
        $error("popcount_unary_tx: need 2**CW > N and 2**AW >= 2*N");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [N-1:0]  therm_q;
    logic          therm_valid_q;
    logic          clamp_q;
    logic [N-1:0]  therm_next;
    logic [CW-1:0] cnt_sat;
    logic          over;
    logic          bit_cur;
    logic          accept;
    logic          handshake;
    logic          idx_last;

    assign over      = (cnt_i > CW'(N));
    assign cnt_sat   = over ? CW'(N) : cnt_i;
    assign accept    = (state == IDLE) && cnt_valid_i;
    assign handshake = (state == SEND) && bit_ready_i;
    assign idx_last  = (idx == IW'(N - 1));

    // Thermometer word for the count being accepted: bit i is set when i < count.
    for (genvar i = 0; i < N; i++) begin : g_therm
        assign therm_next[i] = (cnt_sat > CW'(i));
    end

`ifdef POPCOUNT_UNARY_SPREAD_EN
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;

    assign acc_sum = acc + AW'(cnt_q);
    assign bit_cur = (acc_sum >= AW'(N));

    // Error accumulator: a one goes out each time acc + cnt reaches N.
    // acc holds during a stall, so bit_o stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc   <= '0;
        end else if (accept) begin
            cnt_q <= cnt_sat;
            acc   <= '0;
        end else if (handshake) begin
            acc <= bit_cur ? (acc_sum - AW'(N)) : acc_sum;
        end
    end
`else
    assign bit_cur = therm_q[idx];
`endif

    // Control FSM: accept a count in IDLE, then send N bits in SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            therm_q       <= '0;
            therm_valid_q <= 1'b0;
            clamp_q       <= 1'b0;
        end else begin
            therm_valid_q <= 1'b0;
            clamp_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cnt_valid_i) begin
                        therm_q       <= therm_next;
                        therm_valid_q <= 1'b1;
                        clamp_q       <= over;
                        idx           <= '0;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (bit_ready_i) begin
                        if (idx_last) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cnt_ready_o   = (state == IDLE);
    assign busy_o        = (state == SEND);
    assign bit_valid_o   = (state == SEND);
    assign bit_o         = (state == SEND) && bit_cur;
    assign bit_last_o    = (state == SEND) && idx_last;
    assign therm_o       = therm_q;
    assign therm_valid_o = therm_valid_q;
    assign clamp_o       = clamp_q;

endmodule

// File: tb/tb_popcount_unary_tx.sv
// Testbench for popcount_unary_tx. The driver sends directed counts. For each
// one it puts the expected thermometer word, the serial bits and the number of
// ones into queues. A monitor running on the falling edge takes entries from
// those queues as the DUT produces output and compares them.
module tb_popcount_unary_tx;

    localparam int N  = 35;
    localparam int CW = 6;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] cnt_i = '0;
    logic          cnt_valid = 1'b0;
    logic          cnt_ready;
    logic          bit_o;
    logic          bit_valid;
    logic          bit_ready = 1'b1;
    logic          bit_last;
    logic [N-1:0]  therm;
    logic          therm_valid;
    logic          clamp;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [1:0]   exp_q[$];    // {last, bit} for each expected serial bit
    logic [N:0]   therm_exp_q[$]; // {clamp, therm}
    int           ones_q[$];    // number of ones expected in each full frame

    logic rand_ready = 1'b0;

    popcount_unary_tx #(.N(N), .CW(CW), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cnt_i         (cnt_i),
        .cnt_valid_i   (cnt_valid),
        .cnt_ready_o   (cnt_ready),
        .bit_o         (bit_o),
        .bit_valid_o   (bit_valid),
        .bit_ready_i   (bit_ready),
        .bit_last_o    (bit_last),
        .therm_o       (therm),
        .therm_valid_o (therm_valid),
        .clamp_o       (clamp),
        .busy_o        (busy)
    );

    // clock and reset
    always #5 clk = ~clk;

    // Sink ready: held high, or random at 50% when rand_ready is set.
    always @(posedge clk) begin
        #1;
        bit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected serial bit i for count c. In spread mode this uses a
    // closed-form floor expression: a one at i when floor((i+1)c/N) steps.
    function automatic logic exp_bit(input int c, input int i);
`ifdef POPCOUNT_UNARY_SPREAD_EN
        return (((i + 1) * c) / N) > ((i * c) / N);
`else
        return i < c;
`endif
    endfunction

    // Driver: offer count c. Push nbits expected bits (N for a full frame).
    // When fixed is set and ready stays high, also check the frame timing.
    task automatic send_count(input int c, input bit fixed, input int nbits);
        int ce;
        int n;
        logic [N-1:0] t;
        ce = (c > N) ? N : c;
        n = 0;
        while (!cnt_ready && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check("cnt_ready_before_accept", cnt_ready, 1);
        for (int i = 0; i < N; i++) t[i] = (i < ce);
        therm_exp_q.push_back({(c > N), t});
        for (int i = 0; i < nbits; i++) exp_q.push_back({(i == N - 1), exp_bit(ce, i)});
        if (nbits == N) ones_q.push_back(ce);
        cnt_i = CW'(c);
        cnt_valid = 1'b1;
        @(posedge clk); #1;
        cnt_valid = 1'b0;
        check("therm_valid_at_t1", therm_valid, 1);
        check("bit_valid_at_t1", bit_valid, 1);
        check("busy_at_t1", busy, 1);
        check("cnt_ready_low_at_t1", cnt_ready, 0);
        if (fixed) begin
            repeat (34) begin @(posedge clk); #1; end
            check("bit_last_on_34", bit_last, 1);
            @(posedge clk); #1;
            check("cnt_ready_at_t36", cnt_ready, 1);
            check("bit_valid_low_at_t36", bit_valid, 0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cnt_ready && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check("idle_timeout", cnt_ready, 1);
    endtask

    // Scoreboard monitor, sampled on the falling edge away from the active edge.
    int   f_ones = 0;
    int   f_hs = 0;
    logic prev_stall = 1'b0;
    logic prev_bit = 1'b0;
    logic prev_last = 1'b0;

    always @(negedge clk) begin
        logic [N:0] te;
        logic [1:0] be;
        int         oe;
        if (rst) begin
            f_ones = 0;
            f_hs = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bit_valid) begin
                check("stall_bit_stable", bit_o, prev_bit);
                check("stall_last_stable", bit_last, prev_last);
            end
            if (therm_valid) begin
                if (therm_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_therm_valid: therm %0h with no count pending", therm);
                end else begin
                    te = therm_exp_q.pop_front();
                    check("therm_word", therm, te[N-1:0]);
                    check("clamp_flag", clamp, te[N]);
                end
            end else if (clamp) begin
                check("clamp_without_therm_valid", clamp, 0);
            end
            if (bit_valid && bit_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bit: bit %0b with no bit pending", bit_o);
                end else begin
                    be = exp_q.pop_front();
                    check("serial_bit", bit_o, be[0]);
                    check("serial_last", bit_last, be[1]);
                end
                f_hs++;
                f_ones += int'(bit_o);
                if (bit_last) begin
                    oe = (ones_q.size() != 0) ? ones_q.pop_front() : -1;
                    check("frame_ones", f_ones, oe);
                    check("frame_handshakes", f_hs, N);
                    f_ones = 0;
                    f_hs = 0;
                end
            end
            prev_stall = bit_valid && !bit_ready;
            prev_bit = bit_o;
            prev_last = bit_last;
        end
    end

    // Stimulus sequence.
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_therm", therm, 0);
        check("rst_therm_valid", therm_valid, 0);
        check("rst_clamp", clamp, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_bit", bit_o, 0);
        check("rst_bit_last", bit_last, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt_ready", cnt_ready, 1);

        send_count(12, 1, N);
        check("therm_12_literal", therm, 35'h0_0000_0FFF);
        send_count(0, 1, N);
        check("therm_0_literal", therm, 35'h0);
        send_count(35, 1, N);
        check("therm_35_literal", therm, 35'h7_FFFF_FFFF);
        send_count(50, 1, N);
        check("therm_50_literal", therm, 35'h7_FFFF_FFFF);

        // Random back-pressure, plus a count offered in mid-frame that must be ignored.
        rand_ready = 1'b1;
        send_count(20, 0, N);
        repeat (8) begin @(posedge clk); #1; end
        cnt_i = CW'(5);
        cnt_valid = 1'b1;
        @(posedge clk); #1;
        cnt_valid = 1'b0;
        check("midframe_not_accepted", cnt_ready, 0);
        wait_idle();
        rand_ready = 1'b0;
        @(posedge clk); #1;

        // Reset while bit 10 of a 30-count frame is on the output.
        send_count(30, 0, 10);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_bit_valid", bit_valid, 0);
        check("abort_bit", bit_o, 0);
        check("abort_bit_last", bit_last, 0);
        check("abort_busy", busy, 0);
        check("abort_therm", therm, 0);
        check("abort_therm_valid", therm_valid, 0);
        check("abort_clamp", clamp, 0);
        check("abort_cnt_ready", cnt_ready, 1);
        send_count(3, 1, N);

        // Spread-pattern vectors (thermometer order when the macro is undefined).
        send_count(7, 1, N);
        send_count(35, 1, N);
        send_count(1, 1, N);

        repeat (4) @(posedge clk);
        #1;
        check("bit_queue_drained", exp_q.size(), 0);
        check("therm_queue_drained", therm_exp_q.size(), 0);
        check("ones_queue_drained", ones_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/popcount_unary_tx.md
Name: popcount_unary_tx

Overview:
- Inverse of the popcount compressors in the ternary-neuron datapath: converts a binary count back into an N-bit unary frame.
- Serialises the frame one bit per cycle over a valid/ready stream to drive on-sensor printed neuron test chains.
- Also exposes the full thermometer word in parallel.
- Sits between the neuron accumulator/readback logic and the serial unary links that feed downstream popcount stages.

Parameters:
- N, 35, frame length in bits; equals the popcount input width.
- CW, 6, count width; must satisfy 2^CW > N.
- AW, 7, accumulator width for spread mode; must satisfy 2^AW >= 2N.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous active-high reset.
- cnt_i  input  CW  count to encode.
- cnt_valid_i  input  1  count offered.
- cnt_ready_o  output  1  block can accept a count.
- bit_o  output  1  current serial unary bit.
- bit_valid_o  output  1  bit_o valid.
- bit_ready_i  input  1  sink accepts bit_o.
- bit_last_o  output  1  current bit is frame index N-1.
- therm_o  output  N  registered thermometer word of latched count.
- therm_valid_o  output  1  one-cycle pulse: therm_o updated.
- clamp_o  output  1  one-cycle pulse with therm_valid_o: input count exceeded N.
- busy_o  output  1  frame in progress.

Behaviour:
- Reset (sync, active-high):
  - FSM to IDLE; index and accumulator to 0.
  - Reset values: therm_o=0, therm_valid_o=0, clamp_o=0, bit_valid_o=0, bit_o=0, bit_last_o=0, busy_o=0, cnt_ready_o=1 from the first cycle after reset.
  - Reset during SEND aborts the frame: no further bits, and the partial frame is not resumed.
- States: IDLE, SEND.
- IDLE:
  - cnt_ready_o=1, bit_valid_o=0.
  - Accept on cnt_valid_i&cnt_ready_o in cycle t:
    - Latch cnt = min(cnt_i, N); clamp_o pulses in t+1 when cnt_i>N.
    - therm_o[i] = (i < cnt), loaded at t+1; held until the next accept or reset.
    - therm_valid_o pulses in t+1.
    - Index and accumulator cleared; move to SEND.
- SEND:
  - cnt_ready_o=0, busy_o=1, bit_valid_o=1 starting at t+1 (first-bit latency = 1 cycle).
  - Thermometer mode: bit_o = therm_o[idx]; frame is idx 0 first, so ones lead.
  - While bit_valid_o & !bit_ready_i: bit_o, bit_last_o and idx hold stable.
  - On handshake: idx increments.
  - bit_last_o = (idx==N-1).
  - Handshake on the last bit → IDLE; cnt_ready_o=1 in the next cycle; bit_valid_o=0 in that cycle.
  - No back-to-back overlap: minimum period is N+1 cycles per count.
- A cnt_valid_i asserted during SEND is ignored (not latched) until IDLE.
- Boundaries:
  - cnt=0 → all-zero frame, still N bits long.
  - cnt=N → all ones.
  - cnt_i in (N, 2^CW-1] → clamped to N.
- Exactly cnt ones are emitted per frame in both modes.

Optional Feature:
- Macro: POPCOUNT_UNARY_SPREAD_EN.
- Defined: ones are distributed evenly across the frame instead of leading.
  - AW-bit accumulator acc, cleared at accept.
  - For the current bit: s = acc + cnt; bit_o = (s >= N).
  - On handshake: acc <= bit_o ? s-N : s; acc stays < N.
  - acc holds during stall, so bit_o is stable.
  - therm_o stays thermometer-coded (unchanged).
- Undefined: thermometer serial order as above; no accumulator logic is instantiated.

Test Plan:
- Reset then cnt_i=12 with bit_ready_i=1:
  - cnt_ready_o=1 before the accept; therm_o=35'h0_0000_0FFF with a therm_valid_o pulse at t+1.
  - Bits 0..11 = 1, bits 12..34 = 0; bit_last_o only on bit 34.
  - cnt_ready_o=1 at cycle t+36.
- cnt_i=0 and cnt_i=35:
  - cnt_i=0 → 35 zeros; cnt_i=35 → 35 ones, therm_o=35'h7_FFFF_FFFF.
  - clamp_o=0 in both cases.
- cnt_i=50:
  - Clamped to 35; clamp_o pulses once with therm_valid_o; frame is all ones.
- cnt_i=20, bit_ready_i toggled randomly 50%:
  - bit_o/bit_last_o stable during stalls; exactly 20 ones; exactly 35 handshakes.
  - A cnt_valid_i pulse mid-frame is not accepted.
- rst asserted at bit index 10 of cnt_i=30:
  - Next cycle all outputs at reset values and cnt_ready_o=1.
  - A new count of 3 yields a clean 3-one frame.
- POPCOUNT_UNARY_SPREAD_EN defined, cnt_i=7:
  - Ones exactly at indices 4,9,14,19,24,29,34.
  - cnt_i=35 → all ones; cnt_i=1 → single one at index 34.
